outp_seg7_driver: RTL

//  Downstream display stage of MINI_CPU: samples the CPU output register and drives six 7-seg digits.

---
 rtl/minicpu_display_pkg.sv | 33 +++
 rtl/outp_seg7_driver_if.sv | 31 +++
 rtl/seg7_decode.sv | 21 ++
 rtl/outp_seg7_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/minicpu_display_pkg.sv
// Shared definitions for the MINI_CPU 7-segment display stage.
//   state_t    : conversion FSM states
//   SEG_BLANK  : all segments off (active-low)
//   SEG_MINUS  : segment g only
//   SEG_TABLE  : decimal digit -> {g,f,e,d,c,b,a}, active-low
//   seg_code() : table lookup, codes above 9 map to blank
package minicpu_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  localparam int unsigned HEX_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Element [0] is the code for digit 0.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_TABLE[digit];
    return seg;
  endfunction

endpackage

// File: rtl/outp_seg7_driver_if.sv
// Display bus between the CPU output register and the 7-segment pins.
//   VALUE      : value to display (driven by the CPU side)
//   HEX0..HEX5 : active-low segments {g,f,e,d,c,b,a}, HEX0 least significant
//   BUSY       : conversion in progress
//   DONE       : one-cycle pulse when the HEX outputs change
// Modports: master = CPU/board side, slave = display driver.
interface outp_seg7_driver_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] VALUE;
  logic [6:0]            HEX0;
  logic [6:0]            HEX1;
  logic [6:0]            HEX2;
  logic [6:0]            HEX3;
  logic [6:0]            HEX4;
  logic [6:0]            HEX5;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output VALUE,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, BUSY, DONE
  );

  modport slave (
    input  VALUE,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, BUSY, DONE
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational single-digit decoder with blanking and sign override.
//   digit : BCD digit 0..9
//   blank : force all segments off
//   minus : show the minus sign instead (wins over blank)
//   seg   : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import minicpu_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_code(digit);
    if (blank) seg = SEG_BLANK;
    if (minus) seg = SEG_MINUS;
  end

endmodule

// File: rtl/outp_seg7_driver.sv
// Display stage of MINI_CPU: watches VALUE, converts it to BCD with a
// sequential double-dabble (one bit per cycle) and drives six registered
// active-low 7-segment digits with leading-zero blanking.
//   CLK  : clock, all registers on the rising edge
//   RST  : synchronous active-high reset
//   disp : outp_seg7_driver_if.slave (VALUE in; HEX0..HEX5, BUSY, DONE out)
// Parameters: DATA_WIDTH (value width), BCD_DIGITS (digits converted).
// Build option: define OUTP_SEG7_SIGNED_EN to treat VALUE as two's complement
// and show a leading minus sign for negative values.
module outp_seg7_driver
  import minicpu_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic              CLK,
  input  logic              RST,
  outp_seg7_driver_if.slave disp
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  if (((64'd10 ** BCD_DIGITS) <= (64'd1 << DATA_WIDTH)) ||
      (BCD_DIGITS > 5) || (BCD_DIGITS == 0)) begin : g_param_check
    $error("outp_seg7_driver: BCD_DIGITS=%0d cannot hold DATA_WIDTH=%0d",
           BCD_DIGITS, DATA_WIDTH);
  end

  state_t                       state, state_next;
  logic [DATA_WIDTH-1:0]        last, last_next;
  logic [DATA_WIDTH-1:0]        bin, bin_next;
  logic [BCD_W-1:0]             bcd, bcd_next, bcd_adj;
  logic [CNT_W-1:0]             cnt, cnt_next;
  logic [HEX_DIGITS-1:0][6:0]   hex_q, hex_next, hex_dec;
  logic                         done_q, done_next;
  logic [HEX_DIGITS-1:0]        show, minus_at;
  logic [DATA_WIDTH-1:0]        mag;

`ifdef OUTP_SEG7_SIGNED_EN
  logic neg, neg_next;
  assign mag = disp.VALUE[DATA_WIDTH-1] ? (~disp.VALUE) + DATA_WIDTH'(1)
                                        : disp.VALUE;
`else
  assign mag = disp.VALUE;
`endif

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit is shown when it is digit 0 or anything at or above it is nonzero.
  always_comb begin
    show = '0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      show[i] = (i == 0) || ((bcd >> (4*i)) != '0);
    end
  end

  // Sign sits at the first blank position above the shown digits.
  always_comb begin
    minus_at = '0;
`ifdef OUTP_SEG7_SIGNED_EN
    for (int unsigned k = 1; k < HEX_DIGITS; k++) begin
      minus_at[k] = neg && show[k-1] && !show[k];
    end
`endif
  end

  for (genvar k = 0; k < HEX_DIGITS; k++) begin : g_digit
    if (k < BCD_DIGITS) begin : g_bcd
      seg7_decode u_dec (
        .digit (bcd[4*k +: 4]),
        .blank (!show[k]),
        .minus (minus_at[k]),
        .seg   (hex_dec[k])
      );
    end else begin : g_pad
      assign hex_dec[k] = minus_at[k] ? SEG_MINUS : SEG_BLANK;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    bin_next   = bin;
    bcd_next   = bcd;
    cnt_next   = cnt;
    hex_next   = hex_q;
    done_next  = 1'b0;
`ifdef OUTP_SEG7_SIGNED_EN
    neg_next   = neg;
`endif
    case (state)
      IDLE: begin
        if (disp.VALUE != last) begin
          state_next = SHIFT;
          last_next  = disp.VALUE;
          bin_next   = mag;
          bcd_next   = '0;
          cnt_next   = '0;
`ifdef OUTP_SEG7_SIGNED_EN
          neg_next   = disp.VALUE[DATA_WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj, bin} << 1;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_next = UPDATE;
      end
      UPDATE: begin
        hex_next   = hex_dec;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      last   <= '0;
      bin    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      hex_q  <= {{(HEX_DIGITS-1){SEG_BLANK}}, seg_code(4'd0)};
`ifdef OUTP_SEG7_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      last   <= last_next;
      bin    <= bin_next;
      bcd    <= bcd_next;
      cnt    <= cnt_next;
      done_q <= done_next;
      hex_q  <= hex_next;
`ifdef OUTP_SEG7_SIGNED_EN
      neg    <= neg_next;
`endif
    end
  end

  assign disp.HEX0 = hex_q[0];
  assign disp.HEX1 = hex_q[1];
  assign disp.HEX2 = hex_q[2];
  assign disp.HEX3 = hex_q[3];
  assign disp.HEX4 = hex_q[4];
  assign disp.HEX5 = hex_q[5];
  assign disp.BUSY = (state != IDLE);
  assign disp.DONE = done_q;

endmodule
